reduce_stream_unit: RTL
=======================

Name: reduce_stream_unit

Overview:
- Streaming, parametrised successor to the combinational reduction-operator checks.
- Accepts multi-beat frames of WIDTH-bit words over a valid/ready handshake and applies one of six reduction ops (AND, OR, XOR, NAND, NOR, XNOR) across the entire frame.
- Returns one registered whole-frame result bit, a per-segment result vector and a beat count per frame.
- Sits in the operator regression fabric as a reference engine for reduction semantics across widths and frame lengths.

Parameters:
- WIDTH, 32, data word width; must be a multiple of SEG.
- SEG, 8, segment width for per-segment reductions; NSEG = WIDTH/SEG.
- BEAT_W, 8, beat counter width; counter saturates at 2^BEAT_W-1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  WIDTH  input word.
- s_last  in  1  final beat of frame.
- s_op  in  3  op code, sampled on first beat only: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 illegal.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid && m_ready.
- m_result  out  1  whole-frame reduction.
- m_seg  out  NSEG  bit k = reduction of bits [k*SEG+SEG-1 : k*SEG] across all beats.
- m_beats  out  BEAT_W  beats in frame, saturating.
- m_err  out  1  illegal op or beat-count saturation.

Behaviour:
- Reset values (synchronous rst=1): state IDLE, m_valid=0, m_result=0, m_seg=0, m_beats=0, m_err=0, internal accumulators 0. s_ready=1 on the first cycle after reset release.
- FSM states:
  - IDLE: waiting for first beat. On accept: latch op, load accumulators from the beat, beats=1. s_last=1 -> DONE, else -> ACCUM.
  - ACCUM: each accepted beat combines into the accumulators and increments beats. Beat with s_last -> DONE.
  - DONE: output registers loaded, m_valid=1. s_ready=0. On m_ready -> IDLE.
- s_ready = (state != DONE). One bubble cycle per frame; no overlap with a held result.
- Latency: m_valid asserts the cycle after the s_last beat is accepted.
- Combining rule: base op = op mod 3 (AND/OR/XOR). Accumulator combines each beat's reduced value with the base op. Output is inverted when op >= 3.
  - Result: NAND = ~AND over all frame bits, not XOR-style chaining of per-beat NANDs.
- Per-segment: NSEG parallel accumulators, same rule, same inversion.
- Single-beat frame (s_last on the first beat): result equals the plain reduction of that word. beats=1.
- Illegal op (6/7): frame is consumed normally. m_result=0, m_seg=0, m_err=1.
- Beat saturation: beats holds at 2^BEAT_W-1. m_err=1 if more than 2^BEAT_W-1 beats arrive. Reduction stays exact regardless.
- s_op on non-first beats is ignored.
- m_* outputs hold stable while m_valid && !m_ready.
- rst mid-frame or mid-DONE: partial frame is discarded, outputs return to reset values the next cycle, no result is emitted.
- Inputs are ignored when s_valid=0. Stalls of any length mid-frame do not alter the accumulators.

Decomposition:
- Shared package/header reduce_pkg: op-code localparams (OP_AND..OP_XNOR), OP_W=3, and a function for base-op selection and inversion.
- One sub-module: reduce_word, purely combinational. Takes a WIDTH-bit word plus the base op and returns the 1-bit whole-word reduction and the NSEG segment reductions.
- The FSM, accumulators and counter live in the top.

Test Plan:
- Single beat, op=AND, data=32'hFFFFFFFF -> m_result=1, m_seg=4'hF, m_beats=1, m_err=0, m_valid one cycle after accept.
- 3 beats, op=XOR, data 32'h0000000F, 32'h00000007, 32'h00000000 -> parity 7 ones, m_result=1; m_seg=4'b0001; m_beats=3.
- 2 beats, op=NAND, data 32'hFFFFFFFF then 32'hFFFFFFFE -> m_result=1, m_seg=4'b0001. Same beats with op=NOR -> m_result=0, m_seg=4'h0.
- op=6, 2 beats of any data -> frame consumed, m_result=0, m_seg=0, m_err=1. Next frame with op=OR, data=32'h0 -> m_err=0, m_result=0.
- m_ready held 0 for 5 cycles after a result -> outputs stable, s_ready=0 throughout. Release -> s_ready=1 next cycle. rst asserted mid-frame after 2 beats -> no m_valid; next frame result is unaffected.
- BEAT_W=2, 5-beat OR frame with one 1 in beat 5 -> m_beats=3, m_err=1, m_result=1.

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared op-code definitions and helpers for the streaming reduction engine.
// Op codes map onto a base op (AND/OR/XOR) plus an optional output inversion.
package reduce_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_op_e;

  typedef struct packed {
    base_op_e base;
    logic     inv;
    logic     illegal;
  } op_dec_t;

  function automatic op_dec_t op_decode(input logic [OP_W-1:0] op);
    op_dec_t d;
    case (op)
      OP_AND, OP_NAND: d.base = BASE_AND;
      OP_OR,  OP_NOR:  d.base = BASE_OR;
      OP_XOR, OP_XNOR: d.base = BASE_XOR;
      default:         d.base = BASE_AND;
    endcase
    d.illegal = (op > OP_XNOR);
    d.inv     = (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    return d;
  endfunction

  function automatic logic combine(input base_op_e base, input logic a, input logic b);
    case (base)
      BASE_OR:  return a | b;
      BASE_XOR: return a ^ b;
      default:  return a & b;
    endcase
  endfunction

endpackage

// File: rtl/reduce_stream_unit_if.sv
// Beat input stream and frame result stream of reduce_stream_unit.
// The slave modport is the engine's view; master is the producer/consumer side.
interface reduce_stream_unit_if #(
  parameter int WIDTH  = 32,
  parameter int SEG    = 8,
  parameter int BEAT_W = 8
);
  logic                       s_valid;
  logic                       s_ready;
  logic [WIDTH-1:0]           s_data;
  logic                       s_last;
  logic [reduce_pkg::OP_W-1:0] s_op;
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_result;
  logic [WIDTH/SEG-1:0]       m_seg;
  logic [BEAT_W-1:0]          m_beats;
  logic                       m_err;

  modport master (
    output s_valid, s_data, s_last, s_op, m_ready,
    input  s_ready, m_valid, m_result, m_seg, m_beats, m_err
  );

  modport slave (
    input  s_valid, s_data, s_last, s_op, m_ready,
    output s_ready, m_valid, m_result, m_seg, m_beats, m_err
  );
endinterface

// File: rtl/reduce_word.sv
// Combinational single-word reduction: whole-word bit plus one bit per SEG-wide segment,
// all using the same base op (AND/OR/XOR).
module reduce_word
  import reduce_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic [WIDTH-1:0]     word,
  input  base_op_e             base,
  output logic                 red,
  output logic [WIDTH/SEG-1:0] seg
);

  localparam int NSEG = WIDTH / SEG;

  always_comb begin
    red = 1'b0;
    seg = '0;
    case (base)
      BASE_OR:  red = |word;
      BASE_XOR: red = ^word;
      default:  red = &word;
    endcase
    for (int k = 0; k < NSEG; k++) begin
      case (base)
        BASE_OR:  seg[k] = |word[k*SEG +: SEG];
        BASE_XOR: seg[k] = ^word[k*SEG +: SEG];
        default:  seg[k] = &word[k*SEG +: SEG];
      endcase
    end
  end

endmodule

// File: rtl/reduce_stream_unit.sv
// Streaming whole-frame reduction engine: folds each accepted beat into running
// accumulators with the frame's base op and presents one registered result per frame.
module reduce_stream_unit
  import reduce_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SEG    = 8,
  parameter int BEAT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  reduce_stream_unit_if.slave bus
);

  localparam int NSEG = WIDTH / SEG;
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            state;
  op_dec_t           op_q;
  logic              acc_q;
  logic [NSEG-1:0]   acc_seg_q;
  logic [BEAT_W-1:0] beats_q;
  logic              sat_q;

  logic              m_valid_q;
  logic              m_result_q;
  logic [NSEG-1:0]   m_seg_q;
  logic [BEAT_W-1:0] m_beats_q;
  logic              m_err_q;

  logic              s_ready_w;
  logic              accept;
  op_dec_t           op_cur;
  logic              word_red;
  logic [NSEG-1:0]   word_seg;
  logic              acc_nxt;
  logic [NSEG-1:0]   acc_seg_nxt;
  logic [BEAT_W-1:0] beats_nxt;
  logic              sat_nxt;

  assign s_ready_w = (state != S_DONE);
  assign accept    = bus.s_valid && s_ready_w;

  // The op is only taken from the bus on the first beat; later beats use the latched copy.
  assign op_cur = (state == S_IDLE) ? op_decode(bus.s_op) : op_q;

  reduce_word #(
    .WIDTH (WIDTH),
    .SEG   (SEG)
  ) u_word (
    .word (bus.s_data),
    .base (op_cur.base),
    .red  (word_red),
    .seg  (word_seg)
  );

  always_comb begin
    acc_nxt     = word_red;
    acc_seg_nxt = word_seg;
    beats_nxt   = BEAT_W'(1);
    sat_nxt     = 1'b0;
    if (state != S_IDLE) begin
      acc_nxt = combine(op_cur.base, acc_q, word_red);
      for (int k = 0; k < NSEG; k++) begin
        acc_seg_nxt[k] = combine(op_cur.base, acc_seg_q[k], word_seg[k]);
      end
      // Counter holds at its ceiling; any beat beyond it flags the frame.
      if (beats_q == BEAT_MAX) begin
        beats_nxt = beats_q;
        sat_nxt   = 1'b1;
      end else begin
        beats_nxt = beats_q + BEAT_W'(1);
        sat_nxt   = sat_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      acc_q      <= 1'b0;
      acc_seg_q  <= '0;
      beats_q    <= '0;
      sat_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_result_q <= 1'b0;
      m_seg_q    <= '0;
      m_beats_q  <= '0;
      m_err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            op_q      <= op_cur;
            acc_q     <= acc_nxt;
            acc_seg_q <= acc_seg_nxt;
            beats_q   <= beats_nxt;
            sat_q     <= sat_nxt;
            if (bus.s_last) begin
              state      <= S_DONE;
              m_valid_q  <= 1'b1;
              m_result_q <= op_cur.illegal ? 1'b0 : (acc_nxt ^ op_cur.inv);
              m_seg_q    <= op_cur.illegal ? '0 : (acc_seg_nxt ^ {NSEG{op_cur.inv}});
              m_beats_q  <= beats_nxt;
              m_err_q    <= op_cur.illegal | sat_nxt;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (bus.m_ready) begin
            state     <= S_IDLE;
            m_valid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready  = s_ready_w;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_result = m_result_q;
  assign bus.m_seg    = m_seg_q;
  assign bus.m_beats  = m_beats_q;
  assign bus.m_err    = m_err_q;

endmodule
